// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter that sequences operations through one shared, registered ALU.
// Optional statistics counters are enabled with the ALU_ARBITER_STATS_EN macro.
module alu_arbiter #(
  parameter int WIDTH     = 4,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  input  logic                 i_req0_valid,
  input  logic                 i_req1_valid,
  output logic                 o_req0_ready,
  output logic                 o_req1_ready,
  input  logic [WIDTH-1:0]     i_req0_arg0,
  input  logic [WIDTH-1:0]     i_req0_arg1,
  input  logic [1:0]           i_req0_oper,
  input  logic [WIDTH-1:0]     i_req1_arg0,
  input  logic [WIDTH-1:0]     i_req1_arg1,
  input  logic [1:0]           i_req1_oper,
  output logic                 o_rsp0_valid,
  output logic                 o_rsp1_valid,
  input  logic                 i_rsp0_ready,
  input  logic                 i_rsp1_ready,
  output logic [WIDTH-1:0]     o_rsp_result,
  output logic [3:0]           o_rsp_flag,
  output logic [WIDTH-1:0]     o_alu_arg0,
  output logic [WIDTH-1:0]     o_alu_arg1,
  output logic [1:0]           o_alu_oper,
  input  logic [WIDTH-1:0]     i_alu_result,
  input  logic [3:0]           i_alu_flag,
  output logic                 o_busy,
  output logic [CNT_WIDTH-1:0] o_op_cnt,
  output logic [CNT_WIDTH-1:0] o_err_cnt
);

  typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_t;

  state_t r_state;
  state_t w_next;
  logic   r_last;
  logic   r_gnt;
  logic   w_gnt;
  logic   w_acc;
  logic   w_rsp_hs;

  // On a tie the requester that did not win last time gets the grant.
  always_comb begin
    w_gnt = i_req1_valid;
    if (i_req0_valid && i_req1_valid) w_gnt = ~r_last;
  end

  // Readies are gated by reset so every output reads 0 while reset is held.
  assign o_req0_ready = i_rstn & (r_state == IDLE) & i_req0_valid & ~w_gnt;
  assign o_req1_ready = i_rstn & (r_state == IDLE) & i_req1_valid &  w_gnt;
  assign w_acc        = o_req0_ready | o_req1_ready;
  assign w_rsp_hs     = (o_rsp0_valid & i_rsp0_ready) | (o_rsp1_valid & i_rsp1_ready);
  assign o_busy       = (r_state != IDLE);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_acc) w_next = EXEC;
      EXEC:    w_next = CAPT;
      CAPT:    w_next = RESP;
      RESP:    if (w_rsp_hs) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_last       <= 1'b1;
      r_gnt        <= 1'b0;
      o_alu_arg0   <= '0;
      o_alu_arg1   <= '0;
      o_alu_oper   <= '0;
      o_rsp_result <= '0;
      o_rsp_flag   <= '0;
      o_rsp0_valid <= 1'b0;
      o_rsp1_valid <= 1'b0;
    end else begin
      if (w_acc) begin
        o_alu_arg0 <= w_gnt ? i_req1_arg0 : i_req0_arg0;
        o_alu_arg1 <= w_gnt ? i_req1_arg1 : i_req0_arg1;
        o_alu_oper <= w_gnt ? i_req1_oper : i_req0_oper;
        r_gnt      <= w_gnt;
        r_last     <= w_gnt;
      end
      // ALU output is valid during CAPT; it is only ever seen through these registers.
      if (r_state == CAPT) begin
        o_rsp_result <= i_alu_result;
        o_rsp_flag   <= i_alu_flag;
        o_rsp0_valid <= ~r_gnt;
        o_rsp1_valid <=  r_gnt;
      end
      if ((r_state == RESP) && w_rsp_hs) begin
        o_rsp0_valid <= 1'b0;
        o_rsp1_valid <= 1'b0;
      end
    end
  end

`ifdef ALU_ARBITER_STATS_EN
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_op_cnt  <= '0;
      o_err_cnt <= '0;
    end else if (w_rsp_hs) begin
      o_op_cnt <= sat_inc(o_op_cnt);
      if (o_rsp_flag[0]) o_err_cnt <= sat_inc(o_err_cnt);
    end
  end
`else
  assign o_op_cnt  = '0;
  assign o_err_cnt = '0;
`endif

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer that shares one registered ALU instance (1-cycle registered result/flag path, oper codes 00..11) between two clients.
- Accepts one operation at a time via valid/ready, drives the ALU operand/oper inputs, captures result and flags after the ALU latency, and returns them to the winning requester via a valid/ready response channel.
- Sits between client blocks and the ALU top.

Parameters:
- WIDTH, 4, operand/result width; must match the ALU instance.
- CNT_WIDTH, 8, width of the statistics counters (used only with the optional feature).

Ports:
- i_clk  input  1  clock.
- i_rstn  input  1  asynchronous active-low reset.
- i_req0_valid / i_req1_valid  input  1  requester N has an operation.
- o_req0_ready / o_req1_ready  output  1  arbiter accepts requester N this cycle.
- i_req0_arg0 / i_req1_arg0  input  WIDTH  operand 0 (signed).
- i_req0_arg1 / i_req1_arg1  input  WIDTH  operand 1 (signed).
- i_req0_oper / i_req1_oper  input  2  ALU operation code.
- o_rsp0_valid / o_rsp1_valid  output  1  response for requester N is available.
- i_rsp0_ready / i_rsp1_ready  input  1  requester N takes the response.
- o_rsp_result  output  WIDTH  shared response result.
- o_rsp_flag  output  4  shared response flags, ALU encoding {ovf,pos,neg,err}.
- o_alu_arg0 / o_alu_arg1  output  WIDTH  to ALU operands.
- o_alu_oper  output  2  to ALU oper.
- i_alu_result  input  WIDTH  from ALU result.
- i_alu_flag  input  4  from ALU flag.
- o_busy  output  1  state != IDLE.
- o_op_cnt  output  CNT_WIDTH  completed operations (optional feature).
- o_err_cnt  output  CNT_WIDTH  completed operations with err flag set (optional feature).

Behaviour:
- Reset (async, i_rstn=0): state=IDLE, all o_* = 0, r_last=1 (req0 wins the first tie). Any in-flight operation is dropped; no response is issued for it.
- FSM states: IDLE -> EXEC -> CAPT -> RESP -> IDLE.
- IDLE:
  - Grant is combinational. Only req0 valid -> grant 0. Only req1 valid -> grant 1. Both valid -> grant the one != r_last.
  - o_reqN_ready = (state==IDLE) & grant==N. Readies are mutually exclusive and are 0 in every other state.
  - On handshake: register the winner's arg0/arg1/oper into o_alu_*, set r_gnt=N and r_last=N, go to EXEC.
- EXEC: 1 cycle; ALU samples o_alu_* at the closing edge. Go to CAPT.
- CAPT: 1 cycle; i_alu_result/i_alu_flag are valid. At the closing edge, latch them into o_rsp_result/o_rsp_flag, set o_rsp{r_gnt}_valid=1, go to RESP.
- RESP:
  - o_rsp{r_gnt}_valid held high; result/flag held stable until i_rsp{r_gnt}_ready=1.
  - On that edge, valid drops and state returns to IDLE.
  - The non-granted rsp_ready is ignored; the non-granted rsp_valid stays 0.
- Latency: the response becomes valid 3 cycles after the accepting cycle. Minimum issue interval is 4 cycles (a zero-wait response allows a new accept in the following IDLE cycle).
- o_alu_* hold their last value outside a handshake. o_rsp_result/o_rsp_flag hold their last value after the response completes.
- Request inputs are ignored while ready=0. A requester may drop valid before acceptance without effect.
- Requests arriving during EXEC/CAPT/RESP wait. Fairness: with both valid continuously, grants alternate 0,1,0,1,...
- No combinational path from i_alu_* to any output.

Optional Feature:
- Macro: ALU_ARBITER_STATS_EN.
- Defined:
  - o_op_cnt increments by 1 on every response handshake (rsp_valid & rsp_ready).
  - o_err_cnt increments on a response handshake when o_rsp_flag[0]=1.
  - Both saturate at all-ones; both reset to 0.
- Undefined: both ports present and tied to 0; no counter logic.

Test Plan:
- req0 {arg0=5, arg1=3, oper=00}, rsp0_ready=1 -> o_req0_ready=1 in the accept cycle; o_rsp0_valid rises 3 cycles later with o_rsp_result=2, o_rsp_flag=4'b0100; o_rsp1_valid stays 0.
- req1 {arg0=3, arg1=5, oper=00} -> o_rsp1_valid with o_rsp_result=4'b1110 (-2), o_rsp_flag=4'b0010.
- Both valid from reset and held (req0 5-3, req1 3-5), ready=1 -> grant order 0,1,0,1; results alternate 2, -2; each accept 4 cycles apart.
- Response backpressure: rsp0_ready=0 for 5 cycles, req1 valid meanwhile -> o_rsp0_valid, o_rsp_result and o_rsp_flag stable; o_req1_ready=0 throughout; req1 accepted the cycle after the rsp0 handshake.
- Reset mid-op: assert i_rstn=0 during CAPT -> all outputs 0 immediately; after release, no stale response; next tie grants req0.
- With ALU_ARBITER_STATS_EN and CNT_WIDTH=2: 5 completed ops, one returning err=1 -> o_op_cnt=3 (saturated), o_err_cnt=1. Without the macro, both read 0.
